// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_pkg : shared FSM encoding, defaults and range check for dmem blocks  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
   localparam int          CNT_W             = 4;

   // offset is (addr - base) mod 2^32, so addresses below base wrap to huge indices
   function automatic logic addr_error(input logic [31:0] offset, input int unsigned depth);
      return (offset[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= 32'(depth));
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_array : word array, one sync write port, registered read, no reset   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wdata;
      if (rd_en) rdata <= mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : multi-cycle load/store responder with range checking    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int             AW       = $clog2(DEPTH_WORDS);
   localparam logic           ZERO_LAT = (LATENCY == 0);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lat_write, lat_err;
   logic [AW-1:0]    lat_idx;
   logic [31:0]      lat_wdata;
   logic [31:0]      req_offset;
   logic             req_err, accept, commit;
   logic             acc_write, acc_err;
   logic [AW-1:0]    acc_idx;
   logic [31:0]      acc_wdata;
   logic [31:0]      arr_rdata;

   assign req_offset = req_addr - BASE_ADDR;
   assign req_err    = addr_error(req_offset, DEPTH_WORDS);
   assign accept     = (state == IDLE) && req_valid;

   // With zero latency the access commits on the handshake edge, straight from the inputs
   assign acc_write = (state == IDLE) ? req_write : lat_write;
   assign acc_err   = (state == IDLE) ? req_err : lat_err;
   assign acc_idx   = (state == IDLE) ? req_offset[AW+1:2] : lat_idx;
   assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
   assign commit    = (accept && ZERO_LAT) || ((state == WAIT) && (cnt == '0));

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .wr_en (commit && acc_write && !acc_err),
      .rd_en (commit && !acc_write && !acc_err),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_offset[AW+1:2];
            lat_wdata <= req_wdata;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (ZERO_LAT) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = lat_err;
            resp_rdata = (lat_write || lat_err) ? '0 : arr_rdata;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench, LATENCY=2 (dut 0) and 0 (dut 1)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [1:0]       req_valid, req_write;
   logic [1:0][31:0] req_addr, req_wdata;
   wire  [1:0]       req_ready, resp_valid, resp_err;
   wire  [1:0][31:0] resp_rdata;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_resp(input int d);
      exp_t e;
      int   n;
      n = (d == 0) ? q0.size() : q1.size();
      if (n == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0 (cycle %0d)", d, cyc);
      end else begin
         if (d == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         cmp($sformatf("resp_rdata dut%0d", d), resp_rdata[d], e.rdata);
         cmp($sformatf("resp_err dut%0d", d), 32'(resp_err[d]), 32'(e.err));
         cmp($sformatf("resp_cycle dut%0d", d), 32'(cyc), 32'(e.due));
      end
   endtask

   // Monitor: every presented response is checked against the scoreboard
   always @(negedge clk) begin
      if (resp_valid[0]) check_resp(0);
      if (resp_valid[1]) check_resp(1);
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic wait_accept(input int d, input logic [31:0] exp_rd, input logic exp_err,
                              input logic push, output int acc_cyc);
      exp_t e;
      logic got;
      got     = 1'b0;
      acc_cyc = -1;
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk);
         if (req_ready[d]) begin
            got     = 1'b1;
            acc_cyc = cyc;
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.due   = cyc + lat_of(d) + 1;
            if (push) begin
               if (d == 0) q0.push_back(e);
               else        q1.push_back(e);
            end
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout dut%0d: got no req_ready expected accept", d);
      end
   endtask

   task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      int acc;
      @(posedge clk); #1;
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      wait_accept(d, exp_rd, exp_err, 1'b1, acc);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'hFFFF_FFFF;
      @(negedge clk);
      for (int k = 0; k < lat_of(d); k++) begin
         cmp($sformatf("ready_busy dut%0d", d), 32'(req_ready[d]), 32'd0);
         @(negedge clk);
      end
      cmp($sformatf("ready_busy_last dut%0d", d), 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      cmp($sformatf("ready_back dut%0d", d), 32'(req_ready[d]), 32'd1);
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      cmp($sformatf("%s req_ready dut%0d", tag, d), 32'(req_ready[d]), 32'd1);
      cmp($sformatf("%s resp_valid dut%0d", tag, d), 32'(resp_valid[d]), 32'd0);
      cmp($sformatf("%s resp_rdata dut%0d", tag, d), resp_rdata[d], 32'd0);
      cmp($sformatf("%s resp_err dut%0d", tag, d), 32'(resp_err[d]), 32'd0);
   endtask

   initial begin
      logic [31:0] sdata [6];
      logic        swr   [6];
      int          acc, prev;

      reset     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs(0, "reset");
      check_reset_outputs(1, "reset");
      reset = 1'b1;

      // Basic store/load, LATENCY=2 and LATENCY=0
      issue(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(0, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0);
      issue(1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(1, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0);
      issue(1, 1'b0, 32'h1001_0006, 32'h0, 32'h0, 1'b1);
      issue(1, 1'b1, 32'h1001_0400, 32'h1, 32'h0, 1'b1);
      issue(1, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Error and boundary addresses
      issue(0, 1'b0, 32'h1001_0006, 32'h0, 32'h0, 1'b1);
      issue(0, 1'b0, 32'h1001_0400, 32'h0, 32'h0, 1'b1);
      issue(0, 1'b1, 32'h1001_0000, 32'hA5A5_A5A5, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h1001_03FC, 32'h5555_AAAA, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h1000_FFFC, 32'h0000_0001, 32'h0, 1'b1);
      issue(0, 1'b0, 32'h1001_0000, 32'h0, 32'hA5A5_A5A5, 1'b0);
      issue(0, 1'b0, 32'h1001_03FC, 32'h0, 32'h5555_AAAA, 1'b0);

      // req_valid held high; junk stores presented while busy must be ignored
      swr   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      sdata = '{32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0, 32'h3333_3333, 32'h0};
      prev  = -1;
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_write[0] = swr[0];
      req_addr[0]  = 32'h1001_0000;
      req_wdata[0] = sdata[0];
      for (int i = 0; i < 6; i++) begin
         wait_accept(0, (i % 2 == 1) ? sdata[i-1] : 32'h0, 1'b0, 1'b1, acc);
         if (i > 0) cmp("accept_spacing", 32'(acc - prev), 32'd4);
         prev = acc;
         @(posedge clk); #1;
         if (i == 5) begin
            req_valid[0] = 1'b0;
         end else begin
            req_write[0] = 1'b1;
            req_wdata[0] = 32'hBAD0_BAD0;
            repeat (3) @(posedge clk);
            #1;
            req_write[0] = swr[i+1];
            req_wdata[0] = sdata[i+1];
         end
      end
      repeat (4) @(negedge clk);

      // Reset during WAIT cycle 1 drops the uncommitted store
      issue(0, 1'b1, 32'h1001_0010, 32'hCAFE_F00D, 32'h0, 1'b0);
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h1001_0010;
      req_wdata[0] = 32'h1234_5678;
      @(negedge clk);
      cmp("rst_wait accept_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      cmp("rst_wait busy_ready", 32'(req_ready[0]), 32'd0);
      reset = 1'b0;
      #1;
      check_reset_outputs(0, "rst_wait");
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      issue(0, 1'b0, 32'h1001_0010, 32'h0, 32'hCAFE_F00D, 1'b0);

      // Reset during RESP keeps the committed store
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h1001_0014;
      req_wdata[0] = 32'h0BAD_F00D;
      @(negedge clk);
      cmp("rst_resp accept_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      cmp("rst_resp valid_before", 32'(resp_valid[0]), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs(0, "rst_resp");
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      issue(0, 1'b0, 32'h1001_0014, 32'h0, 32'h0BAD_F00D, 1'b0);

      for (int n = 0; n < 20 && (q0.size() + q1.size()) != 0; n++) @(negedge clk);
      if ((q0.size() + q1.size()) != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_responses: got %0d outstanding expected 0", q0.size() + q1.size());
      end
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
